// File: rtl/pipeline_ctrl.sv
// CPU control unit: holds the control registers, commits WRCR/EXRT/exceptions at MEM,
// takes external interrupts at EX and drives per-stage stall/flush plus the redirect PC.
module pipeline_ctrl #(
    parameter int          IRQ_W   = 8,
    parameter logic [29:0] VEC_RST = 30'h0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [4:0]       creg_rd_addr,
    output logic [31:0]      creg_rd_data,
    output logic             exe_mode,
    output logic             int_en,
    input  logic [IRQ_W-1:0] irq,
    input  logic             ld_hazard,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             ex_en,
    input  logic [29:0]      ex_pc,
    input  logic             mem_en,
    input  logic [29:0]      mem_pc,
    input  logic [1:0]       mem_ctrl_op,
    input  logic [4:0]       mem_dst_addr,
    input  logic [31:0]      mem_out,
    input  logic [2:0]       mem_exp_code,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic [29:0]      new_pc
);

    localparam logic [4:0] CREG_STATUS     = 5'd0;
    localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
    localparam logic [4:0] CREG_EPC        = 5'd2;
    localparam logic [4:0] CREG_EXP_VECTOR = 5'd3;
    localparam logic [4:0] CREG_CAUSE      = 5'd4;
    localparam logic [4:0] CREG_INT_MASK   = 5'd5;
    localparam logic [4:0] CREG_IRQ        = 5'd6;

    localparam logic [1:0] OP_WRCR = 2'd1;
    localparam logic [1:0] OP_EXRT = 2'd2;

    localparam logic [2:0] EXP_NONE    = 3'd0;
    localparam logic [2:0] EXP_EXT_INT = 3'd1;

    logic [1:0]       pre_status;
    logic [29:0]      epc;
    logic [29:0]      exp_vector;
    logic [2:0]       cause;
    logic [IRQ_W-1:0] int_mask;

    logic stall_all;
    logic exc_req;
    logic exrt_req;
    logic int_req;
    logic wrcr_req;

    // Event decode in priority order; a bus wait freezes everything.
    always_comb begin
        stall_all = if_busy | mem_busy;
        exc_req   = mem_en && (mem_exp_code != EXP_NONE);
        exrt_req  = mem_en && (mem_ctrl_op == OP_EXRT) && !exc_req;
        int_req   = int_en && (|(irq & ~int_mask)) && ex_en && !exc_req && !exrt_req;
        wrcr_req  = mem_en && (mem_ctrl_op == OP_WRCR) && !exc_req;
    end

    function automatic logic [31:0] creg_read(
        input logic [4:0]       addr,
        input logic [1:0]       status,
        input logic [1:0]       pre,
        input logic [29:0]      epc_v,
        input logic [29:0]      vec_v,
        input logic [2:0]       cause_v,
        input logic [IRQ_W-1:0] mask_v,
        input logic [IRQ_W-1:0] irq_v
    );
        logic [31:0] data;
        data = 32'h0;
        case (addr)
            CREG_STATUS:     data = {30'b0, status};
            CREG_PRE_STATUS: data = {30'b0, pre};
            CREG_EPC:        data = {epc_v, 2'b00};
            CREG_EXP_VECTOR: data = {vec_v, 2'b00};
            CREG_CAUSE:      data = {29'b0, cause_v};
            CREG_INT_MASK:   data = {{(32-IRQ_W){1'b0}}, mask_v};
            CREG_IRQ:        data = {{(32-IRQ_W){1'b0}}, irq_v};
            default:         data = 32'h0;
        endcase
        return data;
    endfunction

    always_comb begin
        creg_rd_data = creg_read(creg_rd_addr, {int_en, exe_mode}, pre_status, epc,
                                 exp_vector, cause, int_mask, irq);
    end

    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        mem_stall = 1'b0;
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        new_pc    = 30'h0;
        if (!reset_) begin
            new_pc = 30'h0;
        end else if (stall_all) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
        end else if (exc_req) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            new_pc    = exp_vector;
        end else if (exrt_req) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            new_pc    = epc;
        end else if (int_req) begin
            // The MEM instruction still retires, so its stage is left alone.
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            new_pc    = exp_vector;
        end else if (ld_hazard) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            exe_mode   <= 1'b0;
            int_en     <= 1'b0;
            pre_status <= 2'b00;
            epc        <= 30'h0;
            exp_vector <= VEC_RST;
            cause      <= 3'd0;
            int_mask   <= '1;
        end else if (!stall_all) begin
            if (wrcr_req) begin
                case (mem_dst_addr)
                    CREG_STATUS:     {int_en, exe_mode} <= mem_out[1:0];
                    CREG_PRE_STATUS: pre_status <= mem_out[1:0];
                    CREG_EPC:        epc <= mem_out[31:2];
                    CREG_EXP_VECTOR: exp_vector <= mem_out[31:2];
                    CREG_CAUSE:      cause <= mem_out[2:0];
                    CREG_INT_MASK:   int_mask <= mem_out[IRQ_W-1:0];
                    default:         ;
                endcase
            end
            // Later assignments win: an interrupt overrides a same-cycle WRCR to the
            // registers it saves, and PRE_STATUS captures the pre-write STATUS.
            if (exc_req) begin
                pre_status <= {int_en, exe_mode};
                exe_mode   <= 1'b0;
                int_en     <= 1'b0;
                epc        <= mem_pc;
                cause      <= mem_exp_code;
            end else if (exrt_req) begin
                {int_en, exe_mode} <= pre_status;
            end else if (int_req) begin
                pre_status <= {int_en, exe_mode};
                exe_mode   <= 1'b0;
                int_en     <= 1'b0;
                epc        <= ex_pc;
                cause      <= EXP_EXT_INT;
            end
        end
    end

endmodule
